// File: rtl/hazard_unit.sv
// Pipeline sequencing controller: load-use stall detection plus the UART program-download sequence.
// Define HAZARD_STAT_EN to add the saturating load-use stall counter output stall_count.
module hazard_unit #(
    parameter int DRAIN_CYCLES = 4,
    parameter int STAT_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_start,
    input  logic       uart_done,
    input  logic [4:0] id_reg_1_idx,
    input  logic [4:0] id_reg_2_idx,
    input  logic       reg_1_valid,
    input  logic       reg_2_valid,
    input  logic [4:0] ex_reg_dest_idx,
    input  logic       ex_mem_read,
    input  logic       ex_no_op,
    output logic [1:0] hazard_control,
    output logic       uart_disable,
    output logic       pc_reset
`ifdef HAZARD_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] stall_count
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        UART,
        RESTART
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic             load_use;

    // A load in EX whose destination feeds a live ID source; register 0 is never a real dependency.
    assign load_use = ex_mem_read && !ex_no_op && (ex_reg_dest_idx != 5'd0) &&
                      ((reg_1_valid && (id_reg_1_idx == ex_reg_dest_idx)) ||
                       (reg_2_valid && (id_reg_2_idx == ex_reg_dest_idx)));

    // uart_disable and pc_reset are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            drain_cnt    <= '0;
            uart_disable <= 1'b1;
            pc_reset     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (uart_start) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state        <= UART;
                        uart_disable <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                UART: begin
                    if (uart_done) begin
                        state        <= RESTART;
                        uart_disable <= 1'b1;
                        pc_reset     <= 1'b1;
                    end
                end
                RESTART: begin
                    state    <= RUN;
                    pc_reset <= 1'b0;
                end
                default: begin
                    state        <= RUN;
                    uart_disable <= 1'b1;
                    pc_reset     <= 1'b0;
                end
            endcase
        end
    end

    // RESTART releases the PC hold so the pc_reset pulse lands, but still bubbles ID/EX.
    always_comb begin
        hazard_control = 2'b11;
        case (state)
            RUN:     hazard_control = load_use ? 2'b11 : 2'b00;
            RESTART: hazard_control = 2'b10;
            default: hazard_control = 2'b11;
        endcase
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((state == RUN) && load_use && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table-driven load-use vectors plus download/reset/saturation sequences.
// Stall counter checks are active only when HAZARD_STAT_EN is defined.
module tb_hazard_unit;

    typedef struct {
        string      name;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       v1;
        logic       v2;
        logic [4:0] dest;
        logic       mr;
        logic       nop;
        logic [1:0] hc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       uart_start;
    logic       uart_done;
    logic [4:0] id_reg_1_idx;
    logic [4:0] id_reg_2_idx;
    logic       reg_1_valid;
    logic       reg_2_valid;
    logic [4:0] ex_reg_dest_idx;
    logic       ex_mem_read;
    logic       ex_no_op;
    logic [1:0] hazard_control;
    logic       uart_disable;
    logic       pc_reset;
    logic [1:0] hazard_control_1;
    logic       uart_disable_1;
    logic       pc_reset_1;
`ifdef HAZARD_STAT_EN
    logic [1:0] stall_count;
    logic [1:0] stall_count_1;
`endif

    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    vec_t vecs[9];

    hazard_unit #(.DRAIN_CYCLES(4), .STAT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .uart_start(uart_start), .uart_done(uart_done),
        .id_reg_1_idx(id_reg_1_idx), .id_reg_2_idx(id_reg_2_idx),
        .reg_1_valid(reg_1_valid), .reg_2_valid(reg_2_valid),
        .ex_reg_dest_idx(ex_reg_dest_idx), .ex_mem_read(ex_mem_read), .ex_no_op(ex_no_op),
        .hazard_control(hazard_control), .uart_disable(uart_disable), .pc_reset(pc_reset)
`ifdef HAZARD_STAT_EN
        , .stall_count(stall_count)
`endif
    );

    // Second instance exercises the single-cycle drain boundary on the same stimulus.
    hazard_unit #(.DRAIN_CYCLES(1), .STAT_WIDTH(2)) dut_1 (
        .clk(clk), .rst(rst), .uart_start(uart_start), .uart_done(uart_done),
        .id_reg_1_idx(id_reg_1_idx), .id_reg_2_idx(id_reg_2_idx),
        .reg_1_valid(reg_1_valid), .reg_2_valid(reg_2_valid),
        .ex_reg_dest_idx(ex_reg_dest_idx), .ex_mem_read(ex_mem_read), .ex_no_op(ex_no_op),
        .hazard_control(hazard_control_1), .uart_disable(uart_disable_1), .pc_reset(pc_reset_1)
`ifdef HAZARD_STAT_EN
        , .stall_count(stall_count_1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setIdle();
        uart_start      = 1'b0;
        uart_done       = 1'b0;
        id_reg_1_idx    = 5'd0;
        id_reg_2_idx    = 5'd0;
        reg_1_valid     = 1'b0;
        reg_2_valid     = 1'b0;
        ex_reg_dest_idx = 5'd0;
        ex_mem_read     = 1'b0;
        ex_no_op        = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        id_reg_1_idx    = v.r1;
        id_reg_2_idx    = v.r2;
        reg_1_valid     = v.v1;
        reg_2_valid     = v.v2;
        ex_reg_dest_idx = v.dest;
        ex_mem_read     = v.mr;
        ex_no_op        = v.nop;
    endtask

    task automatic driveHazard();
        id_reg_2_idx    = 5'd5;
        reg_2_valid     = 1'b1;
        ex_reg_dest_idx = 5'd5;
        ex_mem_read     = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input logic [1:0] hc, input logic ud, input logic pr);
        checkOutput($sformatf("%s.hazard_control", name), 32'(hazard_control), 32'(hc));
        checkOutput($sformatf("%s.uart_disable", name), 32'(uart_disable), 32'(ud));
        checkOutput($sformatf("%s.pc_reset", name), 32'(pc_reset), 32'(pr));
    endtask

    task automatic checkStall(input string name);
`ifdef HAZARD_STAT_EN
        checkOutput($sformatf("%s.stall_count", name), 32'(stall_count), 32'(exp_stall));
`else
        if (name.len() < 0) $display("[TB] %s", name);
`endif
    endtask

    task automatic bumpStall();
        if (exp_stall < 3) exp_stall++;
    endtask

    initial begin
        logic [1:0] ehc;
        logic       eud;

        vecs[0] = '{"dep_r2",      5'd0,  5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 2'b11};
        vecs[1] = '{"dest_zero",   5'd0,  5'd0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 2'b00};
        vecs[2] = '{"r2_invalid",  5'd0,  5'd5, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 2'b00};
        vecs[3] = '{"dep_r1",      5'd7,  5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 2'b11};
        vecs[4] = '{"not_load",    5'd7,  5'd0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 2'b00};
        vecs[5] = '{"ex_bubble",   5'd7,  5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 2'b00};
        vecs[6] = '{"no_match",    5'd3,  5'd4, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 2'b00};
        vecs[7] = '{"dep_r31",     5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 2'b11};
        vecs[8] = '{"r1inv_r2dep", 5'd9,  5'd9, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 2'b11};

        rst = 1'b1;
        setIdle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkState("reset", 2'b00, 1'b1, 1'b0);
        checkStall("reset");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkState($sformatf("idle%0d", i), 2'b00, 1'b1, 1'b0);
        end

        // Load-use vectors; each stall must clear once the inputs move on.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            checkStall($sformatf("before_%s", vecs[i].name));
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkState(vecs[i].name, vecs[i].hc, 1'b1, 1'b0);
            if (vecs[i].hc == 2'b11) bumpStall();
        end
        @(posedge clk);
        #1;
        checkStall("after_vectors");
        setIdle();

        // Download: start in cycle 0, stray done in DRAIN, stray start in UART, done in cycle 20.
        for (int c = 0; c <= 22; c++) begin
            setIdle();
            uart_start = (c == 0) || (c == 8);
            uart_done  = (c == 1) || (c == 20);
            if (c == 10) driveHazard();
            @(negedge clk);
            ehc = (c == 0) ? 2'b00 : (c <= 20) ? 2'b11 : (c == 21) ? 2'b10 : 2'b00;
            eud = (c >= 5 && c <= 20) ? 1'b0 : 1'b1;
            checkState($sformatf("dl_c%0d", c), ehc, eud, (c == 21));
            checkOutput($sformatf("dl1_c%0d.uart_disable", c), 32'(uart_disable_1),
                        32'((c >= 2 && c <= 20) ? 1'b0 : 1'b1));
            checkOutput($sformatf("dl1_c%0d.pc_reset", c), 32'(pc_reset_1), 32'(c == 21));
            @(posedge clk);
            #1;
        end
        checkStall("after_download");

        // Hazard coinciding with start, then reset while in UART aborts without pc_reset.
        for (int c = 0; c <= 9; c++) begin
            setIdle();
            if (c == 0) begin
                uart_start = 1'b1;
                driveHazard();
            end
            rst = (c == 6);
            @(negedge clk);
            ehc = (c <= 6) ? 2'b11 : 2'b00;
            eud = (c == 5 || c == 6) ? 1'b0 : 1'b1;
            checkState($sformatf("rst_c%0d", c), ehc, eud, 1'b0);
            checkOutput($sformatf("rst1_c%0d.pc_reset", c), 32'(pc_reset_1), 32'd0);
            if (c == 0) bumpStall();
            if (c == 6) exp_stall = 0;
            @(posedge clk);
            #1;
            if (c == 7) checkStall("post_reset");
        end
        rst = 1'b0;

        // Consecutive hazards walk the 2-bit counter up to its saturation value.
        for (int c = 0; c < 7; c++) begin
            setIdle();
            if (c < 5) driveHazard();
            @(negedge clk);
            checkState($sformatf("sat_c%0d", c), (c < 5) ? 2'b11 : 2'b00, 1'b1, 1'b0);
            if (c < 5) bumpStall();
            @(posedge clk);
            #1;
            checkStall($sformatf("sat_c%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline sequencing controller for the five-stage CPU. Detects load-use data hazards and generates the per-cycle `hazard_control` hold/bubble vector consumed by `instruction_mem`, `if_id_reg` and `id_ex_reg`. Also owns the UART program-download sequence:
- drain the pipeline;
- hand instruction memory to the UART loader;
- pulse `pc_reset` so execution restarts at address 0.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: bubble cycles inserted before UART takeover, so in-flight instructions retire.
- `STAT_WIDTH`, default 32: width of the stall counter (only with `HAZARD_STAT_EN`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart_start`  in  1  level request to enter download mode; sampled only in RUN.
- `uart_done`  in  1  loader finished; sampled only in UART.
- `id_reg_1_idx`, `id_reg_2_idx`  in  5  ID-stage source register indices.
- `reg_1_valid`, `reg_2_valid`  in  1  the corresponding source is actually read.
- `ex_reg_dest_idx`  in  5  EX-stage destination index.
- `ex_mem_read`  in  1  EX-stage instruction is a load.
- `ex_no_op`  in  1  EX stage holds a bubble.
- `hazard_control`  out  2  bit0 HOLD: freeze PC and IF/ID. bit1 NO_OP: inject a bubble into ID/EX.
- `uart_disable`  out  1  1 = instruction memory owned by the pipeline; 0 = owned by the UART loader.
- `pc_reset`  out  1  one-cycle pulse that forces PC to 0.
- `stall_count`  out  STAT_WIDTH  load-use stall cycles since reset (only with `HAZARD_STAT_EN`).

## Operation
States: RUN, DRAIN, UART, RESTART.

Transitions:
- RUN → DRAIN when `uart_start` = 1.
- DRAIN → UART after `DRAIN_CYCLES` cycles, counted by an internal down-counter loaded with `DRAIN_CYCLES - 1` on entry.
- UART → RESTART when `uart_done` = 1.
- RESTART → RUN unconditionally, after 1 cycle.

Load-use hazard, evaluated in RUN only:
- Condition: `ex_mem_read` & !`ex_no_op` & `ex_reg_dest_idx` != 0 & ((`reg_1_valid` & `id_reg_1_idx` == `ex_reg_dest_idx`) | (`reg_2_valid` & `id_reg_2_idx` == `ex_reg_dest_idx`)).
- When true, `hazard_control` = 2'b11 for that cycle.
- After one bubble the load has left EX, so the hazard self-clears. Stall length is exactly 1 cycle per load-use pair.

`hazard_control` by state:
- RUN: 2'b11 on hazard, else 2'b00.
- DRAIN: 2'b11.
- UART: 2'b11.
- RESTART: 2'b10. The PC update is released so `pc_reset` takes effect; ID/EX still receives a bubble.

`uart_disable` = 0 in UART only; 1 in all other states. `pc_reset` = 1 in RESTART only.

Priority and boundary conditions:
- Download sequencing overrides the load-use check. A hazard coinciding with `uart_start` produces 2'b11 either way, and DRAIN follows next cycle.
- `uart_start` outside RUN is ignored. `uart_done` outside UART is ignored.
- `uart_start` held high through RESTART re-enters DRAIN one cycle after returning to RUN. This is legal.
- A destination index of 0 never stalls.
- `DRAIN_CYCLES` = 1 means a single DRAIN cycle.

## Timing
- `hazard_control` is combinational from the state register and current-cycle inputs, so a stall applies in the same cycle the hazard is visible.
- `uart_disable` and `pc_reset` are decoded from the state register only (Moore), so they are glitch-free for the UART clock domain boundary.
- Download sequence latency: `uart_start` high at edge N puts the unit in DRAIN from N+1 to N+DRAIN_CYCLES. UART (`uart_disable` = 0) starts at N+DRAIN_CYCLES+1. `uart_done` seen at edge M gives RESTART at M+1 and RUN at M+2.
- Reset (`rst` = 1 at an edge):
  - state RUN, drain counter 0, `stall_count` 0;
  - outputs next cycle: `uart_disable` = 1, `pc_reset` = 0, `hazard_control` = 00 absent hazard.
- Reset during DRAIN or UART aborts the sequence. No `pc_reset` pulse is issued; the system reset restarts the PC.

## Configuration
- `HAZARD_STAT_EN` defined:
  - `stall_count` port exists;
  - increments by 1 on every RUN-state cycle with a load-use hazard;
  - saturates at all-ones; cleared by `rst`.
- Not defined: port, counter and `STAT_WIDTH` usage are compiled out. Behaviour is otherwise identical.

## Test plan
- Reset, then idle inputs → `hazard_control` = 00, `uart_disable` = 1, `pc_reset` = 0 for 10 cycles.
- `ex_mem_read` = 1, `ex_reg_dest_idx` = 5, `id_reg_2_idx` = 5, `reg_2_valid` = 1 for 1 cycle → `hazard_control` = 11 that cycle only, `stall_count` = 1. Same with dest = 0, or with `reg_2_valid` = 0 → no stall.
- `uart_start` pulse at cycle 0, `DRAIN_CYCLES` = 4 → `hazard_control` = 11 cycles 1-4, `uart_disable` = 0 from cycle 5. `uart_done` at cycle 20 → `pc_reset` = 1 and `hazard_control` = 10 at cycle 21, RUN at 22.
- `uart_done` asserted during DRAIN, and `uart_start` asserted during UART → both ignored; state sequence unchanged.
- `rst` asserted in UART state → next cycle RUN, `uart_disable` = 1, no `pc_reset` pulse.
- With `HAZARD_STAT_EN` and `STAT_WIDTH` = 2, five consecutive hazard cycles → `stall_count` saturates at 3.
